multicycle_cpu_ctrl: RTL and testbench

//  Parametrised multi-cycle sequencer for the RISC core: owns PC, IR and the phase FSM
//  (FETCH/DECODE/EXEC/MEM/WB) and drives IMem, IDecode, RegisterFile, ALU and data memory.

---
 rtl/multicycle_cpu_ctrl_if.sv | 40 ++++
 rtl/multicycle_cpu_ctrl.sv | 144 ++++++++++++++
 tb/tb_multicycle_cpu_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_cpu_ctrl_if.sv
// Sequencer-side bus bundle: fetch port, decode/branch inputs, datapath strobes and status.
interface multicycle_cpu_ctrl_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned CNT_W   = 32
);
    logic               run;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] ir;
    logic [2:0]         dec_class;
    logic               br_taken;
    logic [ADDR_W-1:0]  br_target;
    logic               alu_en;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ready;
    logic               rf_we;
    logic [ADDR_W-1:0]  pc;
    logic               retire;
    logic [CNT_W-1:0]   instret;
    logic               halted;
    logic               illegal;

    // Sequencer side
    modport master (
        input  run, imem_ready, imem_rdata, dec_class, br_taken, br_target, dmem_ready,
        output imem_req, imem_addr, ir, alu_en, dmem_req, dmem_we, rf_we, pc, retire,
               instret, halted, illegal
    );

    // Memories / datapath side
    modport slave (
        output run, imem_ready, imem_rdata, dec_class, br_taken, br_target, dmem_ready,
        input  imem_req, imem_addr, ir, alu_en, dmem_req, dmem_we, rf_we, pc, retire,
               instret, halted, illegal
    );
endinterface

// File: rtl/multicycle_cpu_ctrl.sv
// Multi-cycle sequencer: owns PC, IR and the FETCH/DECODE/EXEC/MEM/WB phase FSM, handshakes
// with variable-latency instruction/data memories and counts retired instructions.
module multicycle_cpu_ctrl #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    multicycle_cpu_ctrl_if.master bus
);

    localparam logic [2:0] ClsAlu    = 3'd0;
    localparam logic [2:0] ClsLoad   = 3'd1;
    localparam logic [2:0] ClsStore  = 3'd2;
    localparam logic [2:0] ClsBranch = 3'd3;
    localparam logic [2:0] ClsHalt   = 3'd4;

    localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(PC_STEP);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalted
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [2:0]         cls_q, cls_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               illegal_q, illegal_d;
    logic               retire_q, retire_d;
    logic               take_br;

    // Phase sequencing; retire_d marks the cycle an instruction completes.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cls_d     = cls_q;
        illegal_d = illegal_q;
        retire_d  = 1'b0;
        take_br   = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (bus.run && bus.imem_ready) begin
                    ir_d    = bus.imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                cls_d   = bus.dec_class;
                state_d = StExec;
            end
            StExec: begin
                case (cls_q)
                    ClsAlu:           state_d = StWb;
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsBranch: begin
                        take_br  = bus.br_taken;
                        retire_d = 1'b1;
                        state_d  = StFetch;
                    end
                    ClsHalt: begin
                        retire_d = 1'b1;
                        state_d  = StHalted;
                    end
                    default: begin
                        // Undefined class: stop without retiring it
                        illegal_d = 1'b1;
                        state_d   = StHalted;
                    end
                endcase
            end
            StMem: begin
                if (bus.dmem_ready) begin
                    if (cls_q == ClsStore) begin
                        retire_d = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                retire_d = 1'b1;
                state_d  = StFetch;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StFetch;
        endcase
    end

    // Architectural update on retire: next PC and instret, both wrapping naturally.
    always_comb begin
        pc_d      = pc_q;
        instret_d = instret_q;
        if (retire_d) begin
            pc_d      = take_br ? bus.br_target : pc_q + PcStep;
            instret_d = instret_q + 1'b1;
        end
    end

    // State and architectural registers; async reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            cls_q     <= ClsAlu;
            instret_q <= '0;
            illegal_q <= 1'b0;
            retire_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            cls_q     <= cls_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            retire_q  <= retire_d;
        end
    end

    // Strobes decoded from the registered phase
    assign bus.imem_req  = (state_q == StFetch) && bus.run;
    assign bus.imem_addr = pc_q;
    assign bus.ir        = ir_q;
    assign bus.alu_en    = (state_q == StExec);
    assign bus.dmem_req  = (state_q == StMem);
    assign bus.dmem_we   = (state_q == StMem) && (cls_q == ClsStore);
    assign bus.rf_we     = (state_q == StWb);
    assign bus.pc        = pc_q;
    assign bus.retire    = retire_q;
    assign bus.instret   = instret_q;
    assign bus.halted    = (state_q == StHalted);
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_cpu_ctrl.sv
// Directed bench for multicycle_cpu_ctrl: per-class latency, strobe counts, PC/instret
// updates, halt/illegal handling and asynchronous reset mid-transaction.
module tb_multicycle_cpu_ctrl;

    logic clk;
    logic rst_n;

    multicycle_cpu_ctrl_if b ();
    multicycle_cpu_ctrl_if b2 ();

    multicycle_cpu_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    multicycle_cpu_ctrl #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int cyc;
        int ireq;
        int alu;
        int dreq;
        int dwe;
        int rf;
        int rf_at;
        bit done;
    } stats_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction on the main DUT; memories answer after iw/dw request cycles.
    task automatic exec_instr(input logic [2:0] cls, input logic [31:0] word, input int iw,
                              input int dw, input logic tk, input logic [31:0] tgt,
                              output stats_t st);
        int fi;
        int mi;
        bit fetched;
        st = '{default: 0};
        fi = 0;
        mi = 0;
        fetched = 1'b0;
        b.run        = 1'b1;
        b.imem_rdata = word;
        b.dec_class  = cls;
        b.br_taken   = tk;
        b.br_target  = tgt;
        while (!st.done && st.cyc < 40) begin
            b.imem_ready = (fi >= iw);
            b.dmem_ready = (mi >= dw);
            #1;
            if (b.imem_req) begin
                st.ireq++;
                fi++;
                if (b.imem_ready) fetched = 1'b1;
            end
            if (b.alu_en) st.alu++;
            if (b.dmem_req) begin
                st.dreq++;
                mi++;
            end
            if (b.dmem_we) st.dwe++;
            if (b.rf_we) begin
                st.rf++;
                st.rf_at = st.cyc + 1;
            end
            @(posedge clk);
            #1;
            st.cyc++;
            if (fetched) b.run = 1'b0;
            st.done = b.retire || b.halted;
        end
        b.imem_ready = 1'b0;
        b.dmem_ready = 1'b0;
    endtask

    stats_t st;
    int     n;

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        b.run = 1'b0;  b.imem_ready = 1'b0; b.imem_rdata = '0; b.dec_class = '0;
        b.br_taken = 1'b0; b.br_target = '0; b.dmem_ready = 1'b0;
        b2.run = 1'b0; b2.imem_ready = 1'b0; b2.imem_rdata = '0; b2.dec_class = '0;
        b2.br_taken = 1'b0; b2.br_target = '0; b2.dmem_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", b.pc, 0);
        check("rst_wrap_pc", b2.pc, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        step();
        check("rst_instret", b.instret, 0);
        check("rst_ir", b.ir, 0);
        check("rst_status", {b.halted, b.illegal, b.retire}, 0);
        check("rst_strobes", {b.imem_req, b.alu_en, b.dmem_req, b.dmem_we, b.rf_we}, 0);
        b.run = 1'b1;
        #1;
        check("rst_in_fetch", b.imem_req, 1);
        b.run = 1'b0;

        // Wrapping reset PC; no fetch request while run=0
        b2.imem_ready = 1'b1;
        n = 0;
        repeat (4) begin
            if (b2.imem_req) n++;
            step();
        end
        check("run0_no_req", n, 0);
        b2.run = 1'b1; b2.dec_class = 3'd0; b2.imem_rdata = 32'h13;
        step();
        b2.run = 1'b0;
        repeat (3) step();
        check("wrap_retire", b2.retire, 1);
        check("wrap_pc", b2.pc, 0);
        check("wrap_instret", b2.instret, 1);
        b2.imem_ready = 1'b0;

        // ALU, zero-wait
        exec_instr(3'd0, 32'h0000_1234, 0, 0, 1'b0, 32'h0, st);
        check("alu_done", st.done, 1);
        check("alu_cycles", st.cyc, 4);
        check("alu_ir", b.ir, 32'h0000_1234);
        check("alu_rf", st.rf, 1);
        check("alu_rf_at", st.rf_at, 4);
        check("alu_en_cnt", st.alu, 1);
        check("alu_dreq", st.dreq, 0);
        check("alu_retire", b.retire, 1);
        check("alu_pc", b.pc, 32'h4);
        check("alu_instret", b.instret, 1);
        step();
        check("alu_retire_pulse", b.retire, 0);

        // LOAD, dmem_ready 3 cycles late
        exec_instr(3'd1, 32'h0000_0003, 0, 3, 1'b0, 32'h0, st);
        check("ld_cycles", st.cyc, 8);
        check("ld_dreq", st.dreq, 4);
        check("ld_dwe", st.dwe, 0);
        check("ld_rf_at", st.rf_at, 8);
        check("ld_pc", b.pc, 32'h8);
        check("ld_instret", b.instret, 2);

        // STORE, zero-wait
        exec_instr(3'd2, 32'h0000_0023, 0, 0, 1'b0, 32'h0, st);
        check("st_cycles", st.cyc, 4);
        check("st_dreq", st.dreq, 1);
        check("st_dwe", st.dwe, 1);
        check("st_rf", st.rf, 0);
        check("st_pc", b.pc, 32'hC);
        check("st_instret", b.instret, 3);

        // ALU with two imem wait cycles
        exec_instr(3'd0, 32'h0000_0033, 2, 0, 1'b0, 32'h0, st);
        check("aluw_cycles", st.cyc, 6);
        check("aluw_ireq", st.ireq, 3);
        check("aluw_pc", b.pc, 32'h10);

        // Branch taken / not taken
        exec_instr(3'd3, 32'h0000_0063, 0, 0, 1'b1, 32'h40, st);
        check("brt_cycles", st.cyc, 3);
        check("brt_side", st.rf + st.dreq, 0);
        check("brt_pc", b.pc, 32'h40);
        check("brt_instret", b.instret, 5);
        exec_instr(3'd3, 32'h0000_0063, 0, 0, 1'b0, 32'h80, st);
        check("brn_pc", b.pc, 32'h44);
        check("brn_instret", b.instret, 6);

        // Illegal class stops without retiring
        exec_instr(3'd7, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'h0, st);
        check("ill_cycles", st.cyc, 3);
        check("ill_flags", {b.halted, b.illegal, b.retire}, 3'b110);
        check("ill_instret", b.instret, 6);
        b.run = 1'b1;
        b.imem_ready = 1'b1;
        n = 0;
        repeat (5) begin
            #1;
            if (b.imem_req) n++;
            step();
        end
        check("ill_no_fetch", n, 0);
        check("ill_pc_frozen", b.pc, 32'h44);
        b.run = 1'b0;
        b.imem_ready = 1'b0;

        // Reset leaves HALTED
        rst_n = 1'b0;
        #1;
        check("rst_clear_halt", {b.halted, b.illegal}, 0);
        check("rst_clear_pc", b.pc, 0);
        step();
        rst_n = 1'b1;
        step();

        // Reset during MEM aborts the load
        exec_instr(3'd0, 32'h0000_0033, 0, 0, 1'b0, 32'h0, st);
        check("pre_pc", b.pc, 32'h4);
        b.run = 1'b1; b.imem_ready = 1'b1; b.dec_class = 3'd1; b.dmem_ready = 1'b0;
        step();
        b.run = 1'b0;
        step();
        step();
        check("mem_req", {b.dmem_req, b.dmem_we}, 2'b10);
        step();
        check("mem_held", b.dmem_req, 1);
        rst_n = 1'b0;
        #1;
        check("abort_dreq", b.dmem_req, 0);
        check("abort_pc", b.pc, 0);
        check("abort_instret", b.instret, 0);
        check("abort_retire", b.retire, 0);
        b.imem_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // HALT retires, then stops
        exec_instr(3'd4, 32'h0000_0073, 0, 0, 1'b0, 32'h0, st);
        check("halt_cycles", st.cyc, 3);
        check("halt_flags", {b.halted, b.illegal, b.retire}, 3'b101);
        check("halt_instret", b.instret, 1);
        check("halt_pc", b.pc, 32'h4);
        b.run = 1'b1;
        b.imem_ready = 1'b1;
        step();
        check("halt_retire_pulse", b.retire, 0);
        check("halt_no_fetch", b.imem_req, 0);
        step();
        check("halt_pc_frozen", b.pc, 32'h4);
        b.run = 1'b0;
        b.imem_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
